// File: rtl/alu_r_sequencer_if.sv
// Handshake and data bundle between an instruction issuer and alu_r_sequencer.
// Valid/ready rule: a word moves only on a rising edge where its valid and ready are both high.
interface alu_r_sequencer_if;
  logic        iVALID;
  logic        oREADY;
  logic [31:0] iIR;
  logic [31:0] iALU_IN1;
  logic [31:0] iALU_IN2;
  logic        oVALID;
  logic        iREADY;
  logic [4:0]  oRD;
  logic [31:0] oALU_OUT;
  logic        oILLEGAL;
  logic        oBUSY;
  logic [1:0]  oSTATE;

  modport slave (
    input  iVALID, iIR, iALU_IN1, iALU_IN2, iREADY,
    output oREADY, oVALID, oRD, oALU_OUT, oILLEGAL, oBUSY, oSTATE
  );

  modport master (
    output iVALID, iIR, iALU_IN1, iALU_IN2, iREADY,
    input  oREADY, oVALID, oRD, oALU_OUT, oILLEGAL, oBUSY, oSTATE
  );
endinterface

// File: rtl/alu_r_sequencer.sv
// RV32IM R-type execute unit: single-cycle ALU/multiply, 32-cycle restoring divide,
// one instruction in flight, result held until the consumer takes it.
module alu_r_sequencer (
  input  logic             iCLK,
  input  logic             iRST_N,
  alu_r_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, DIV_RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [4:0]  r_rd;
  logic [31:0] r_out;
  logic        r_illegal;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_is_rem;

  logic [6:0]  w_opcode;
  logic [6:0]  w_func7;
  logic [2:0]  w_func3;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [4:0]  w_shamt;
  logic        w_is_r;
  logic        w_base;
  logic        w_alt;
  logic        w_mext;
  logic        w_legal;
  logic        w_is_div;
  logic        w_div_signed;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_div_long;
  logic        w_accept;

  assign w_opcode = bus.iIR[6:0];
  assign w_func3  = bus.iIR[14:12];
  assign w_func7  = bus.iIR[31:25];
  assign w_a      = bus.iALU_IN1;
  assign w_b      = bus.iALU_IN2;
  assign w_shamt  = bus.iALU_IN2[4:0];

  assign w_is_r       = (w_opcode == 7'b0110011);
  assign w_base       = w_is_r && (w_func7 == 7'h00);
  assign w_alt        = w_is_r && (w_func7 == 7'h20) && ((w_func3 == 3'd0) || (w_func3 == 3'd5));
  assign w_mext       = w_is_r && (w_func7 == 7'h01);
  assign w_legal      = w_base || w_alt || w_mext;
  assign w_is_div     = w_mext && w_func3[2];
  assign w_div_signed = !w_func3[0];
  assign w_div_zero   = (w_b == 32'd0);
  assign w_div_ovf    = w_div_signed && (w_a == 32'h8000_0000) && (w_b == 32'hFFFF_FFFF);
  assign w_div_long   = w_is_div && !w_div_zero && !w_div_ovf;
  assign w_accept     = bus.iVALID && (r_state == IDLE);

  // Operands sign- or zero-extended to 33 bits so one unsigned 66-bit multiply covers all four MUL forms.
  logic        w_a_sgn;
  logic        w_b_sgn;
  logic [32:0] w_a_ext;
  logic [32:0] w_b_ext;
  logic [65:0] w_prod;
  logic signed [31:0] w_sra;

  assign w_a_sgn = (w_func3 == 3'd1) || (w_func3 == 3'd2);
  assign w_b_sgn = (w_func3 == 3'd1);
  assign w_a_ext = {w_a_sgn & w_a[31], w_a};
  assign w_b_ext = {w_b_sgn & w_b[31], w_b};
  assign w_prod  = {{33{w_a_ext[32]}}, w_a_ext} * {{33{w_b_ext[32]}}, w_b_ext};
  assign w_sra   = $signed(w_a) >>> w_shamt;

  logic [31:0] w_fast;

  always_comb begin
    w_fast = '0;
    if (w_base) begin
      case (w_func3)
        3'd0:    w_fast = w_a + w_b;
        3'd1:    w_fast = w_a << w_shamt;
        3'd2:    w_fast = {31'd0, ($signed(w_a) < $signed(w_b))};
        3'd3:    w_fast = {31'd0, (w_a < w_b)};
        3'd4:    w_fast = w_a ^ w_b;
        3'd5:    w_fast = w_a >> w_shamt;
        3'd6:    w_fast = w_a | w_b;
        default: w_fast = w_a & w_b;
      endcase
    end else if (w_alt) begin
      w_fast = (w_func3 == 3'd0) ? (w_a - w_b) : w_sra;
    end else if (w_mext) begin
      case (w_func3)
        3'd0:             w_fast = w_prod[31:0];
        3'd1, 3'd2, 3'd3: w_fast = w_prod[63:32];
        3'd4, 3'd5:       w_fast = w_div_zero ? 32'hFFFF_FFFF : (w_div_ovf ? 32'h8000_0000 : 32'h0);
        default:          w_fast = w_div_zero ? w_a : 32'h0;
      endcase
    end
  end

  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;

  assign w_a_neg = w_div_signed && w_a[31];
  assign w_b_neg = w_div_signed && w_b[31];
  assign w_a_mag = w_a_neg ? (32'd0 - w_a) : w_a;
  assign w_b_mag = w_b_neg ? (32'd0 - w_b) : w_b;

  // r_quo starts as the dividend; its MSB shifts into the partial remainder as quotient bits shift in.
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic [31:0] w_div_res;

  assign w_rem_sh  = {r_rem, r_quo[31]};
  assign w_diff    = w_rem_sh - {1'b0, r_dvs};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_nx  = w_ge ? w_diff[31:0] : w_rem_sh[31:0];
  assign w_quo_nx  = {r_quo[30:0], w_ge};
  assign w_div_res = r_is_rem ? (r_neg_r ? (32'd0 - w_rem_nx) : w_rem_nx)
                              : (r_neg_q ? (32'd0 - w_quo_nx) : w_quo_nx);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.iVALID) w_next = w_div_long ? DIV_RUN : DONE;
      DIV_RUN: if (r_cnt == 5'd0) w_next = DONE;
      DONE:    if (bus.iREADY) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_cnt     <= 5'd0;
      r_rd      <= 5'd0;
      r_out     <= 32'd0;
      r_illegal <= 1'b0;
      r_rem     <= 32'd0;
      r_quo     <= 32'd0;
      r_dvs     <= 32'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_is_rem  <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= w_div_long ? 5'd31 : 5'd0;
      r_rd      <= bus.iIR[11:7];
      r_out     <= w_fast;
      r_illegal <= !w_legal;
      r_rem     <= 32'd0;
      r_quo     <= w_a_mag;
      r_dvs     <= w_b_mag;
      r_neg_q   <= w_a_neg ^ w_b_neg;
      r_neg_r   <= w_a_neg;
      r_is_rem  <= w_func3[1];
    end else if (r_state == DIV_RUN) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      if (r_cnt == 5'd0) r_out <= w_div_res;
      else               r_cnt <= r_cnt - 5'd1;
    end
  end

  assign bus.oREADY   = (r_state == IDLE);
  assign bus.oBUSY    = (r_state == DIV_RUN);
  assign bus.oVALID   = (r_state == DONE);
  assign bus.oRD      = r_rd;
  assign bus.oALU_OUT = r_out;
  assign bus.oILLEGAL = r_illegal;
  assign bus.oSTATE   = r_state;

  logic w_unused;
  assign w_unused = &{1'b0, bus.iIR[24:15], w_prod[65:64], w_diff[32]};
endmodule

// File: tb/tb_alu_r_sequencer.sv
// Bench for alu_r_sequencer: directed corner cases plus random R-type traffic,
// scored against an arithmetic reference model through an expected-result queue.
module tb_alu_r_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_r_sequencer_if bus();
  alu_r_sequencer dut (.iCLK(clk), .iRST_N(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [37:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];
  int          busy_cnt = 0;
  bit          seen = 0;
  bit          post_xfer = 0;
  logic [37:0] held = '0;
  bit          rdy_rand = 0;
  logic        rdy_val = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: RV32IM semantics from plain SV arithmetic on 64-bit integers.
  function automatic void ref_model(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output bit ill, output int lat);
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic signed [31:0] sa32;
    longint sa, sb, q;
    longint unsigned ua, ub, uq;
    op = ir[6:0]; f3 = ir[14:12]; f7 = ir[31:25];
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'd0, a}; ub = {32'd0, b};
    res = 32'd0; ill = 0; lat = 1;
    if (op != 7'h33) ill = 1;
    else if (f7 == 7'h00) begin
      case (f3)
        3'd0: res = a + b;
        3'd1: res = a << b[4:0];
        3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: res = (a < b) ? 32'd1 : 32'd0;
        3'd4: res = a ^ b;
        3'd5: res = a >> b[4:0];
        3'd6: res = a | b;
        default: res = a & b;
      endcase
    end else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
    else if (f7 == 7'h20 && f3 == 3'd5) begin
      sa32 = a;
      res = sa32 >>> b[4:0];
    end else if (f7 == 7'h01) begin
      case (f3)
        3'd0: begin q = sa * sb; res = q[31:0]; end
        3'd1: begin q = sa * sb; res = q[63:32]; end
        3'd2: begin q = sa * longint'(ub); res = q[63:32]; end
        3'd3: begin uq = ua * ub; res = uq[63:32]; end
        3'd4: if (b == 0) res = 32'hFFFF_FFFF;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'h8000_0000;
              else begin q = sa / sb; res = q[31:0]; lat = 33; end
        3'd5: if (b == 0) res = 32'hFFFF_FFFF;
              else begin uq = ua / ub; res = uq[31:0]; lat = 33; end
        3'd6: if (b == 0) res = a;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'd0;
              else begin q = sa % sb; res = q[31:0]; lat = 33; end
        default: if (b == 0) res = a;
                 else begin uq = ua % ub; res = uq[31:0]; lat = 33; end
      endcase
    end else ill = 1;
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    logic [9:0] rs;
    rs = 10'($urandom_range(0, 1023));
    return {f7, rs, f3, rd, op};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Inputs change only at posedge+1, so they are stable when the monitor samples at negedge.
  always @(posedge clk) begin
    #1;
    if (rdy_rand) bus.iREADY = ($urandom_range(0, 3) != 0);
    else          bus.iREADY = rdy_val;
  end

  task automatic send(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    bit ill;
    int lat;
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.oREADY && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.oREADY) begin
      checks++; errors++;
      $display("FAIL accept_timeout: oREADY stayed 0 for %0d cycles", n);
      return;
    end
    ref_model(ir, a, b, r, ill, lat);
    bus.iVALID = 1'b1; bus.iIR = ir; bus.iALU_IN1 = a; bus.iALU_IN2 = b;
    @(posedge clk);
    exp_q.push_back({ill, ir[11:7], r});
    lat_q.push_back(lat);
    acc_q.push_back(cyc + 1);
    #1;
    bus.iVALID = 1'b0; bus.iIR = $urandom; bus.iALU_IN1 = $urandom; bus.iALU_IN2 = $urandom;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.oREADY) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || !bus.oREADY) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
    end
  endtask

  always @(negedge clk) begin
    logic [37:0] e;
    int lat;
    int acc;
    if (post_xfer) begin
      chk("ready_after_xfer", 64'(bus.oREADY), 64'd1);
      chk("valid_after_xfer", 64'(bus.oVALID), 64'd0);
      post_xfer = 0;
    end
    if (bus.oBUSY) busy_cnt++;
    if (bus.oVALID) begin
      chk("ready_low_in_done", 64'(bus.oREADY), 64'd0);
      if (!seen) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 64'(bus.oVALID), 64'd0);
        else begin
          e = exp_q.pop_front(); lat = lat_q.pop_front(); acc = acc_q.pop_front();
          chk("alu_out", 64'(bus.oALU_OUT), 64'(e[31:0]));
          chk("rd", 64'(bus.oRD), 64'(e[36:32]));
          chk("illegal", 64'(bus.oILLEGAL), 64'(e[37]));
          chk("latency", 64'(cyc - acc + 1), 64'(lat));
          chk("busy_cycles", 64'(busy_cnt), (lat == 33) ? 64'd32 : 64'd0);
          busy_cnt = 0;
          held = e;
          seen = 1;
        end
      end else begin
        chk("hold_stable", 64'({bus.oILLEGAL, bus.oRD, bus.oALU_OUT}), 64'(held));
      end
      if (bus.iREADY) begin
        seen = 0;
        post_xfer = 1;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"},   64'(bus.oVALID),   64'd0);
    chk({tag, "_ready"},   64'(bus.oREADY),   64'd1);
    chk({tag, "_busy"},    64'(bus.oBUSY),    64'd0);
    chk({tag, "_rd"},      64'(bus.oRD),      64'd0);
    chk({tag, "_out"},     64'(bus.oALU_OUT), 64'd0);
    chk({tag, "_illegal"}, 64'(bus.oILLEGAL), 64'd0);
    chk({tag, "_state"},   64'(bus.oSTATE),   64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  f7;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    bus.iVALID = 1'b0; bus.iIR = '0; bus.iALU_IN1 = '0; bus.iALU_IN2 = '0; bus.iREADY = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    send(enc(7'h00, 3'd0, 5'd5, 7'h33), 32'h7FFF_FFFF, 32'h0000_0001);
    send(enc(7'h20, 3'd5, 5'd9, 7'h33), 32'h8000_0000, 32'h0000_0024);
    send(enc(7'h01, 3'd4, 5'd10, 7'h33), 32'hFFFF_FFF9, 32'h0000_0002);
    send(enc(7'h01, 3'd6, 5'd11, 7'h33), 32'hFFFF_FFF9, 32'h0000_0002);
    send(enc(7'h01, 3'd5, 5'd12, 7'h33), 32'h0000_0005, 32'h0000_0000);
    send(enc(7'h01, 3'd6, 5'd13, 7'h33), 32'h8000_0000, 32'hFFFF_FFFF);
    send(enc(7'h00, 3'd0, 5'd0, 7'h33), 32'h0000_1234, 32'h0000_4321);
    wait_drain();

    rdy_val = 1'b0;
    send(enc(7'h01, 3'd1, 5'd14, 7'h33), 32'h8000_0000, 32'h8000_0000);
    repeat (5) @(posedge clk);
    rdy_val = 1'b1;
    wait_drain();

    send(enc(7'h01, 3'd4, 5'd15, 7'h33), 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.oBUSY), 64'd0);
    chk("abort_valid", 64'(bus.oVALID), 64'd0);
    chk("abort_ready", 64'(bus.oREADY), 64'd1);
    exp_q.delete(); lat_q.delete(); acc_q.delete();
    busy_cnt = 0; seen = 0; post_xfer = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("post_abort_valid", 64'(bus.oVALID), 64'd0);
    chk("post_abort_busy", 64'(bus.oBUSY), 64'd0);
    send(enc(7'h00, 3'd0, 5'd3, 7'h33), 32'd40, 32'd2);
    send(enc(7'h00, 3'd0, 5'd4, 7'h13), 32'd40, 32'd2);
    wait_drain();

    rdy_rand = 1;
    for (int i = 0; i < 120; i++) begin
      rd = 5'($urandom_range(0, 31));
      f3 = 3'($urandom_range(0, 7));
      op = 7'h33;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: f7 = 7'h00;
        4:          f7 = 7'h20;
        5, 6, 7:    f7 = 7'h01;
        8:          f7 = 7'($urandom_range(0, 127));
        default: begin f7 = 7'($urandom_range(0, 127)); op = 7'($urandom_range(0, 127)); end
      endcase
      send(enc(f7, f3, rd, op), pick_operand(), pick_operand());
    end
    wait_drain();
    rdy_rand = 0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
